// File: rtl/alu_pkg.sv
// alu_pkg: op codes, scheduler state codes and datapath width shared by the ALU scheduler
package alu_pkg;
    localparam int ALU_W = 8;
    typedef enum logic [2:0] {
        ALU_FWD = 3'b000,
        ALU_ADD = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011
    } alu_op_e;
    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;
    function automatic logic op_legal(input logic [2:0] op);
        return ~op[2];
    endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; the caller owns the lastGrant register
module rr_arbiter2 (
    input  logic req0,
    input  logic req1,
    input  logic lastGrant,
    output logic grantValid,
    output logic grantIdx
);
    assign grantValid = req0 | req1;
    assign grantIdx   = (req0 & req1) ? ~lastGrant : req1;
endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler: shares one external ALU between two requesters with round-robin grants
module alu_scheduler
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             req0,
    input  logic             req1,
    input  logic [2:0]       op0,
    input  logic [2:0]       op1,
    input  logic [ALU_W-1:0] a0,
    input  logic [ALU_W-1:0] a1,
    input  logic [ALU_W-1:0] b0,
    input  logic [ALU_W-1:0] b1,
    output logic             ack0,
    output logic             ack1,
    output logic             done0,
    output logic             done1,
    output logic [ALU_W-1:0] result0,
    output logic [ALU_W-1:0] result1,
    output logic             error,
    output logic [2:0]       aluSelect,
    output logic [ALU_W-1:0] aluData1,
    output logic [ALU_W-1:0] aluData2,
    input  logic [ALU_W-1:0] aluResult,
    output logic             busy
);
    state_e           r_state, w_next;
    logic [3:0]       r_cnt;
    logic             r_last, r_idx, r_bad;
    logic             w_gv, w_gi, w_start, w_fin;
    logic [2:0]       w_op;
    logic [ALU_W-1:0] w_a, w_b;

    rr_arbiter2 u_arb (
        .req0      (req0),
        .req1      (req1),
        .lastGrant (r_last),
        .grantValid(w_gv),
        .grantIdx  (w_gi)
    );

    assign w_op = w_gi ? op1 : op0;
    assign w_a  = w_gi ? a1 : a0;
    assign w_b  = w_gi ? b1 : b0;
    assign busy = (r_state == EXEC);

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_fin   = 1'b0;
        if (r_state == IDLE) begin
            w_start = w_gv;
            w_next  = w_gv ? EXEC : IDLE;
        end else begin
            w_fin  = (r_cnt == 4'd1);
            w_next = w_fin ? IDLE : EXEC;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt     <= 4'd0;
            r_last    <= 1'b1;
            r_idx     <= 1'b0;
            r_bad     <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            error     <= 1'b0;
            result0   <= '0;
            result1   <= '0;
            aluSelect <= 3'b000;
            aluData1  <= '0;
            aluData2  <= '0;
        end else begin
            ack0  <= w_start & ~w_gi;
            ack1  <= w_start & w_gi;
            done0 <= w_fin & ~r_idx;
            done1 <= w_fin & r_idx;
            error <= w_fin & r_bad;
            if (w_start) begin
                r_idx  <= w_gi;
                r_last <= w_gi;
                r_bad  <= ~op_legal(w_op);
                r_cnt  <= 4'(SETTLE_CYCLES);
                // illegal ops leave the ALU inputs parked on the last legal operation
                if (op_legal(w_op)) begin
                    aluSelect <= w_op;
                    aluData1  <= w_a;
                    aluData2  <= w_b;
                end
            end else if (busy) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_fin && !r_idx) result0 <= r_bad ? '0 : aluResult;
            if (w_fin && r_idx)  result1 <= r_bad ? '0 : aluResult;
        end
    end
endmodule
